// File: rtl/inst_mem_resp_if.sv
// Fetch/response/load bundle between the program-counter side and inst_mem_resp.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// The source holds valid and its payload stable until that edge. Ready may depend
// combinationally on the other side's state, but never on the matching valid.
interface inst_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction memory responder: word-indexed fetch with a single registered response slot.
// Optional accepted-fetch counter on port fetch_count when IMEM_STATS_EN is defined.
module inst_mem_resp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_mem_resp_if.slave       bus
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0]          fetch_count
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_inst_q,  rsp_inst_d;
  logic        rsp_err_q,   rsp_err_d;

  logic req_ready_c;
  logic fire;
  logic req_in_range;
  logic load_in_range;

  // Full 32-bit compares so that indices above DEPTH never alias into the array.
  always_comb begin
    req_ready_c   = !bus.load_en && (!rsp_valid_q || bus.rsp_ready);
    fire          = bus.req_valid && req_ready_c;
    req_in_range  = bus.req_addr  < DEPTH_W;
    load_in_range = bus.load_addr < DEPTH_W;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_inst_d  = rsp_inst_q;
    rsp_err_d   = rsp_err_q;
    if (fire) begin
      rsp_valid_d = 1'b1;
      if (req_in_range) begin
        rsp_inst_d = mem[bus.req_addr[AW-1:0]];
        rsp_err_d  = 1'b0;
      end else begin
        rsp_inst_d = NOP_INST;
        rsp_err_d  = 1'b1;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Program storage survives reset; only the response slot is cleared.
  always_ff @(posedge clk) begin
    if (bus.load_en && load_in_range) begin
      mem[bus.load_addr[AW-1:0]] <= bus.load_data;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef IMEM_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (fire) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_inst_mem_resp.sv
// Self-checking bench for inst_mem_resp: vector table of fetches plus hand-written
// sequences for backpressure, load priority, out-of-range and mid-flight reset.
module tb_inst_mem_resp;

  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h0020_81B3;
  localparam logic [31:0] W3  = 32'h0000_0013;
  localparam logic [31:0] W255 = 32'hCAFE_0255;
  localparam logic [31:0] W44 = 32'h0440_0044;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   fires;

  inst_mem_resp_if bus ();

`ifdef IMEM_STATS_EN
  logic [31:0] fetch_count;
`endif

  inst_mem_resp #(.DEPTH(256), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IMEM_STATS_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  // Scoreboard entry: {err, inst, fire cycle}
  logic [64:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;
  vec_t vecs[8];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: response latency and pop-time compare.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst) begin
      if (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
        check("rsp_latency_valid", 64'(bus.rsp_valid), 64'd1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'({bus.rsp_err, bus.rsp_inst}), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'({bus.rsp_err, bus.rsp_inst}), 64'(e[64:32]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [31:0] a, input logic [31:0] inst, input logic err);
    logic fired;
    fired = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back({err, inst, 32'(cyc)});
        fires++;
        fired = 1'b1;
        break;
      end
    end
    if (!fired) check("fetch_timeout", 64'(fired), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge clk);
    check("load_blocks_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_chk  = 0;
    n_fail = 0;
    fires  = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;

    vecs[0] = '{32'd0,         W0,   1'b0};
    vecs[1] = '{32'd1,         W1,   1'b0};
    vecs[2] = '{32'd2,         W2,   1'b0};
    vecs[3] = '{32'd3,         W3,   1'b0};
    vecs[4] = '{32'd255,       W255, 1'b0};
    vecs[5] = '{32'd256,       NOP,  1'b1};
    vecs[6] = '{32'hFFFF_FFFF, NOP,  1'b1};
    vecs[7] = '{32'd44,        W44,  1'b0};

    #2;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_inst",  64'(bus.rsp_inst),  64'd0);
    check("reset_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
`ifdef IMEM_STATS_EN
    check("reset_fetch_count", 64'(fetch_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_cycle();

    // Program load, then the vector table fetched back-to-back.
    load(32'd0, W0);
    load(32'd1, W1);
    load(32'd2, W2);
    load(32'd3, W3);
    load(32'd255, W255);
    load(32'd44, W44);
    load(32'd300, 32'hBAD0_BAD0);
    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, vecs[i].inst, vecs[i].err);
    end
    next_cycle();

    // Backpressure: response held stable, new fire accepted when consumer returns.
    bus.rsp_ready = 1'b0;
    fetch(32'd1, W1, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_inst",  64'(bus.rsp_inst),  64'(W1));
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    fetch(32'd2, W2, 1'b0);
    next_cycle();

    // Load priority over a simultaneous fetch; fetch next cycle sees new data.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd5;
    load(32'd5, 32'h0555_0005);
    fetch(32'd5, 32'h0555_0005, 1'b0);
    next_cycle();

    // Held response is not disturbed by a load to the same index.
    load(32'd6, 32'h0666_000A);
    bus.rsp_ready = 1'b0;
    fetch(32'd6, 32'h0666_000A, 1'b0);
    load(32'd6, 32'h0666_000B);
    @(negedge clk);
    check("held_rsp_after_load", 64'(bus.rsp_inst), 64'h0666_000A);
    next_cycle();
    bus.rsp_ready = 1'b1;
    next_cycle();
    fetch(32'd6, 32'h0666_000B, 1'b0);
    next_cycle();

    // Reset while a response is pending.
    bus.rsp_ready = 1'b0;
    fetch(32'd0, W0, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", 64'(bus.rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_valid", 64'(bus.rsp_valid), 64'd0);
    check("async_reset_inst",  64'(bus.rsp_inst),  64'd0);
    check("async_reset_err",   64'(bus.rsp_err),   64'd0);
    exp_q.delete();
    fires = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    next_cycle();

    // Post-reset: 5 fires (one out of range), 2 stalled cycles, 1 load.
    fetch(32'd0, W0, 1'b0);
    fetch(32'd256, NOP, 1'b1);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      next_cycle();
    end
    bus.req_valid = 1'b0;
    load(32'd7, 32'h0777_0007);
    bus.rsp_ready = 1'b1;
    fetch(32'd1, W1, 1'b0);
    fetch(32'd2, W2, 1'b0);
    fetch(32'd3, W3, 1'b0);
`ifdef IMEM_STATS_EN
    check("fetch_count", 64'(fetch_count), 64'(fires));
    check("fetch_count_five", 64'(fetch_count), 64'd5);
`endif
    fetch(32'd255, W255, 1'b0);
    fetch(32'd7, 32'h0777_0007, 1'b0);

    // Drain and confirm every expected response was seen.
    for (int i = 0; i < 4; i++) next_cycle();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("final_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
